note_recorder: RTL and testbench

Record-side counterpart of the music-box playback reader. It samples the key inputs and band selector, measures each note or rest duration in playback time units, and writes 12-bit score words to the score RAM. The words use the exact format the playback block consumes, and the recording ends with a zero-length terminator word. It sits between the key/button front end and the RAM write port.

---
 rtl/note_recorder.sv | 271 +++++++++++++++++++++++++++
 tb/tb_note_recorder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// note_recorder: samples key levels and band selector, measures each note or
// rest in playback time units and writes 12-bit score words
// {note[3:0], band[2:0], len[4:0]} to the score RAM. Every recording is
// closed by a 12'h000 terminator word.
// Build option: define NOTE_REC_DEBOUNCE_EN to require the encoded key/band
// pair to be stable for DB_CYCLES cycles before it is accepted.
module note_recorder #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned UNIT_DIV   = 8,
   parameter logic [15:0] LIMIT_ADDR = 16'hFFFF,
   parameter int unsigned DB_CYCLES  = 250000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] keys,
   input  logic [2:0]  band,
   input  logic        rec,
   input  logic [15:0] base_addr,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [11:0] wr_data,
   output logic        recording,
   output logic        full
);

   localparam int unsigned    UNIT      = CLK_HZ / UNIT_DIV;
   localparam int unsigned    UCW       = (UNIT > 1) ? $clog2(UNIT) : 1;
   localparam logic [UCW-1:0] UNIT_LAST = UCW'(UNIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REC, S_FLUSH, S_TERM} state_t;
   state_t state, state_nxt;

   // input pipeline
   logic [15:1] keys_s1, keys_s2;
   logic [2:0]  band_s1, band_s2, band_r;
   logic [3:0]  idx_enc, idx_r;
   logic        rec_d1, rec_d2, rec_d3;

   // accepted input pair and aligned record event
   logic [3:0]  cur_idx;
   logic [2:0]  cur_band;
   logic        rec_ev;
   logic        unused_in;

   // segment measurement and write pointer
   logic [UCW-1:0] unit_cnt, unit_cnt_n;
   logic [4:0]     len, len_n, len_t, emit_len;
   logic [3:0]     seg_idx, seg_idx_n;
   logic [2:0]     seg_band, seg_band_n;
   logic [15:0]    ptr, ptr_n;
   logic           tick, change, sat, at_limit, emit_due, emit, drop;

   // next values of the registered outputs
   logic           wr_en_n, recording_n, full_n;
   logic [15:0]    wr_addr_n;
   logic [11:0]    wr_data_n;

   // Two-flop synchronizer, registered encoder and matching 3-stage rec delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keys_s1 <= '0;
         keys_s2 <= '0;
         band_s1 <= '0;
         band_s2 <= '0;
         band_r  <= '0;
         idx_r   <= '0;
         rec_d1  <= 1'b0;
         rec_d2  <= 1'b0;
         rec_d3  <= 1'b0;
      end else begin
         keys_s1 <= keys[15:1];
         keys_s2 <= keys_s1;
         band_s1 <= band;
         band_s2 <= band_s1;
         band_r  <= band_s2;
         idx_r   <= idx_enc;
         rec_d1  <= rec;
         rec_d2  <= rec_d1;
         rec_d3  <= rec_d2;
      end
   end

   // Priority encoder: highest set key index wins, 0 means rest
   always_comb begin
      idx_enc = '0;
      for (int unsigned i = 1; i < 16; i++) begin
         if (keys_s2[i]) idx_enc = 4'(i);
      end
   end

`ifdef NOTE_REC_DEBOUNCE_EN
   localparam int unsigned    DBW     = $clog2(DB_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [DBW-1:0] DB_LOAD = DBW'(DB_CYCLES);

   logic [6:0]     db_cand, db_acc;
   logic [DBW-1:0] db_cnt, rec_cnt;
   logic           rec_db;

   // Accept the pair once it has held steady for DB_CYCLES; delay rec by the
   // same amount with a down-counter instead of a DB_CYCLES-deep shift chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cand <= '0;
         db_acc  <= '0;
         db_cnt  <= '0;
         rec_cnt <= '0;
         rec_db  <= 1'b0;
      end else begin
         if ({idx_r, band_r} != db_cand) begin
            db_cand <= {idx_r, band_r};
            db_cnt  <= '0;
         end else if (db_cnt != DB_LAST) begin
            db_cnt <= db_cnt + 1'b1;
         end else begin
            db_acc <= db_cand;
         end

         rec_db <= 1'b0;
         if (rec_cnt == DBW'(1)) begin
            rec_db  <= 1'b1;
            rec_cnt <= '0;
         end else if (rec_cnt != '0) begin
            rec_cnt <= rec_cnt - 1'b1;
         end else if (rec_d3) begin
            rec_cnt <= DB_LOAD;
         end
      end
   end

   assign cur_idx   = db_acc[6:3];
   assign cur_band  = db_acc[2:0];
   assign rec_ev    = rec_db;
   assign unused_in = keys[0];
`else
   assign cur_idx   = idx_r;
   assign cur_band  = band_r;
   assign rec_ev    = rec_d3;
   assign unused_in = keys[0] ^ DB_CYCLES[0];
`endif

   assign tick     = (unit_cnt == UNIT_LAST);
   assign len_t    = tick ? len + 5'd1 : len;
   assign change   = ({cur_idx, cur_band} != {seg_idx, seg_band});
   assign sat      = tick && (len_t == 5'd31);
   assign at_limit = (ptr == LIMIT_ADDR);
   assign emit     = emit_due && !at_limit;
   assign drop     = emit_due && at_limit;

   // Decide whether a score word is due this cycle and which length it carries
   always_comb begin
      emit_due = 1'b0;
      emit_len = len_t;
      case (state)
         // rec takes priority over a simultaneous change; the tick still counts
         S_REC:   emit_due = !rec_ev && (change ? (len_t != 5'd0) : sat);
         S_FLUSH: begin
            emit_due = (len != 5'd0);
            emit_len = len;
         end
         default: emit_due = 1'b0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (rec_ev) state_nxt = S_REC;
         S_REC:   begin
            if (rec_ev)    state_nxt = S_FLUSH;
            else if (drop) state_nxt = S_TERM;
         end
         S_FLUSH: state_nxt = S_TERM;
         S_TERM:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath logic: segment counters, write word and pointer update
   always_comb begin
      unit_cnt_n  = unit_cnt;
      len_n       = len;
      seg_idx_n   = seg_idx;
      seg_band_n  = seg_band;
      ptr_n       = ptr;
      wr_en_n     = 1'b0;
      wr_addr_n   = ptr;
      wr_data_n   = wr_data;
      full_n      = full;
      // stays high through the terminator write cycle
      recording_n = (state_nxt != S_IDLE) || (state == S_TERM);

      if (emit) begin
         wr_en_n   = 1'b1;
         wr_data_n = {seg_idx, seg_band, emit_len};
         ptr_n     = ptr + 16'd1;
      end
      if (drop) full_n = 1'b1;

      case (state)
         S_IDLE: begin
            if (rec_ev) begin
               ptr_n      = base_addr;
               wr_addr_n  = base_addr;
               full_n     = 1'b0;
               seg_idx_n  = cur_idx;
               seg_band_n = cur_band;
               unit_cnt_n = '0;
               len_n      = '0;
            end
         end
         S_REC: begin
            if (rec_ev) begin
               unit_cnt_n = tick ? '0 : unit_cnt + 1'b1;
               len_n      = len_t;
            end else if (change) begin
               seg_idx_n  = cur_idx;
               seg_band_n = cur_band;
               unit_cnt_n = '0;
               len_n      = '0;
            end else if (sat) begin
               unit_cnt_n = '0;
               len_n      = '0;
            end else begin
               unit_cnt_n = tick ? '0 : unit_cnt + 1'b1;
               len_n      = len_t;
            end
         end
         S_TERM: begin
            wr_en_n   = 1'b1;
            wr_data_n = '0;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unit_cnt  <= '0;
         len       <= '0;
         seg_idx   <= '0;
         seg_band  <= '0;
         ptr       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         recording <= 1'b0;
         full      <= 1'b0;
      end else begin
         unit_cnt  <= unit_cnt_n;
         len       <= len_n;
         seg_idx   <= seg_idx_n;
         seg_band  <= seg_band_n;
         ptr       <= ptr_n;
         wr_en     <= wr_en_n;
         wr_addr   <= wr_addr_n;
         wr_data   <= wr_data_n;
         recording <= recording_n;
         full      <= full_n;
      end
   end

endmodule

// File: tb/tb_note_recorder.sv
// Bench for note_recorder with UNIT = 80/8 = 10 cycles and LIMIT_ADDR = 0x0202.
// Expected score words are queued as each scenario is driven and compared by
// a write monitor whenever wr_en is seen.
module tb_note_recorder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] keys = '0;
   logic [2:0]  band = '0;
   logic        rec = 1'b0;
   logic [15:0] base_addr = '0;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [11:0] wr_data;
   logic        recording;
   logic        full;

   int errors = 0;
   int checks = 0;

   logic [27:0] sb[$];
   logic        inc_pend  = 1'b0;
   logic [15:0] inc_addr  = '0;
   logic        drop_pend = 1'b0;

   always #5 clk = ~clk;

   note_recorder #(
      .CLK_HZ(80),
      .UNIT_DIV(8),
      .LIMIT_ADDR(16'h0202),
      .DB_CYCLES(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .keys(keys),
      .band(band),
      .rec(rec),
      .base_addr(base_addr),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .recording(recording),
      .full(full)
   );

   // Write monitor: pops the scoreboard on each write, checks address
   // post-increment and the recording drop after the terminator
   always @(negedge clk) begin : monitor
      logic [27:0] exp_w;
      if (inc_pend) begin
         inc_pend = 1'b0;
         checks++;
         if (wr_addr !== inc_addr) begin
            errors++;
            $display("FAIL addr_incr: wr_addr=%h expected %h", wr_addr, inc_addr);
         end
      end
      if (drop_pend) begin
         drop_pend = 1'b0;
         checks++;
         if (recording !== 1'b0) begin
            errors++;
            $display("FAIL rec_drop: recording=%b expected 0", recording);
         end
      end
      if (wr_en === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, expected no write", wr_addr, wr_data);
         end else begin
            exp_w = sb.pop_front();
            if ({wr_addr, wr_data} !== exp_w) begin
               errors++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        wr_addr, wr_data, exp_w[27:12], exp_w[11:0]);
            end
         end
         if (wr_data === 12'h000) begin
            checks++;
            if (recording !== 1'b1) begin
               errors++;
               $display("FAIL rec_during_term: recording=%b expected 1", recording);
            end
            drop_pend = 1'b1;
         end else begin
            inc_pend = 1'b1;
            inc_addr = wr_addr + 16'd1;
         end
      end else if (wr_en !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL wr_en_known: wr_en=%b expected 0 or 1", wr_en);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic expect_word(input logic [15:0] a, input logic [11:0] d);
      sb.push_back({a, d});
   endtask

   task automatic drive_rec(input logic [15:0] k);
      keys = k;
      rec  = 1'b1;
      @(negedge clk);
      rec  = 1'b0;
   endtask

   task automatic hold(input logic [15:0] k, input int n);
      keys = k;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((sb.size() != 0 || recording !== 1'b0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("FAIL %s_done: pending=%0d recording=%b, expected 0 pending and idle",
                  name, sb.size(), recording);
      end
   endtask

   task automatic check_full(input string name, input logic exp);
      checks++;
      if (full !== exp) begin
         errors++;
         $display("FAIL %s_full: full=%b expected %b", name, full, exp);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({wr_en, wr_addr, wr_data, recording, full} !== '0) begin
         errors++;
         $display("FAIL reset_state: en=%b addr=%h data=%h rec=%b full=%b, expected all 0",
                  wr_en, wr_addr, wr_data, recording, full);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // key 5 for 30 cycles then rest for 20 cycles at band 3
   task automatic test_note_rest;
      base_addr = 16'h0100;
      band      = 3'd3;
      expect_word(16'h0100, 12'h563);
      expect_word(16'h0101, 12'h062);
      expect_word(16'h0102, 12'h000);
      drive_rec(16'h0020);
      hold(16'h0020, 29);
      hold(16'h0000, 20);
      drive_rec(16'h0000);
      wait_done("note_rest");
      check_full("note_rest", 1'b0);
   endtask

   // 350 cycles of key 2: saturated word then the 40-cycle remainder
   task automatic test_saturation;
      base_addr = 16'h0010;
      band      = 3'd1;
      expect_word(16'h0010, 12'h23F);
      expect_word(16'h0011, 12'h224);
      expect_word(16'h0012, 12'h000);
      drive_rec(16'h0004);
      hold(16'h0004, 349);
      drive_rec(16'h0004);
      wait_done("saturation");
   endtask

   // keys 3 and 9 together; stop coincides with the release
   task automatic test_priority_rec_wins;
      base_addr = 16'h0040;
      band      = 3'd0;
      expect_word(16'h0040, 12'h902);
      expect_word(16'h0041, 12'h000);
      drive_rec(16'h0208);
      hold(16'h0208, 19);
      drive_rec(16'h0000);
      wait_done("priority");
   endtask

   // 6-cycle key 7 blip inside a rest is discarded
   task automatic test_glitch;
      base_addr = 16'h0080;
      band      = 3'd5;
      expect_word(16'h0080, 12'h0A2);
      expect_word(16'h0081, 12'h0A2);
      expect_word(16'h0082, 12'h000);
      drive_rec(16'h0000);
      hold(16'h0000, 19);
      hold(16'h0080, 6);
      hold(16'h0000, 20);
      drive_rec(16'h0000);
      wait_done("glitch");
   endtask

   // third note hits LIMIT_ADDR: dropped, terminator at the limit, full set
   task automatic test_full;
      base_addr = 16'h0200;
      band      = 3'd2;
      expect_word(16'h0200, 12'h241);
      expect_word(16'h0201, 12'h441);
      expect_word(16'h0202, 12'h000);
      drive_rec(16'h0004);
      hold(16'h0004, 9);
      hold(16'h0010, 10);
      hold(16'h0040, 10);
      hold(16'h0100, 10);
      hold(16'h0000, 5);
      wait_done("full");
      check_full("limit", 1'b1);
      checks++;
      if (recording !== 1'b0) begin
         errors++;
         $display("FAIL limit_recording: recording=%b expected 0", recording);
      end
   endtask

   // next start clears full; reset mid-note aborts with no terminator
   task automatic test_clear_and_abort;
      int n = 0;
      base_addr = 16'h0300;
      band      = 3'd4;
      drive_rec(16'h0020);
      while (recording !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (recording !== 1'b1) begin
         errors++;
         $display("FAIL restart_recording: recording=%b expected 1", recording);
      end
      check_full("restart", 1'b0);
      hold(16'h0020, 3);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, wr_addr, wr_data, recording, full} !== '0) begin
         errors++;
         $display("FAIL abort_reset: en=%b addr=%h data=%h rec=%b full=%b, expected all 0",
                  wr_en, wr_addr, wr_data, recording, full);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold(16'h0020, 30);
      checks++;
      if (recording !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: recording=%b expected 0", recording);
      end
      hold(16'h0000, 5);
   endtask

`ifdef NOTE_REC_DEBOUNCE_EN
   // 4-cycle bounce to key 3 is shorter than DB_CYCLES and must not split the note
   task automatic test_debounce;
      base_addr = 16'h0400;
      band      = 3'd0;
      expect_word(16'h0400, 12'h204);
      expect_word(16'h0401, 12'h000);
      drive_rec(16'h0004);
      hold(16'h0004, 19);
      hold(16'h000C, 4);
      hold(16'h0004, 21);
      drive_rec(16'h0004);
      wait_done("debounce");
   endtask
`endif

   initial begin
      test_reset();
      test_note_rest();
      test_saturation();
      test_priority_rec_wins();
      test_glitch();
      test_full();
      test_clear_and_abort();
`ifdef NOTE_REC_DEBOUNCE_EN
      test_debounce();
`endif
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL leftover: pending=%0d expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
